heart_bank_selector: RTL and testbench

//  Parametrised lives display mux for the player HUD: N heart sprites, one RGB/request out.

---
 rtl/heart_bank_selector.sv | 161 ++++++++++++++++
 tb/tb_heart_bank_selector.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/heart_bank_selector.sv
// Lives display mux for the player HUD: picks the lowest-index visible heart pixel.
// Optional blink of lost hearts is enabled by defining HEART_BLINK_EN.
module heart_bank_selector #(
  parameter int NUM_HEARTS   = 3,
  parameter int LIVES_W      = 3,
  parameter int RGB_W        = 8,
  parameter int BLINK_FRAMES = 32,
  parameter int BLINK_HALF   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_of_frame,
  input  logic [LIVES_W-1:0]          lives,
  input  logic [NUM_HEARTS-1:0]       heart_drawing_requests,
  input  logic [NUM_HEARTS*RGB_W-1:0] heart_rgb,
  output logic                        drawing_request,
  output logic [RGB_W-1:0]            rgb,
  output logic                        blinking
);

  logic                  lives_valid_s;
  logic [NUM_HEARTS-1:0] visible_s;
  logic                  blink_nx_s;
  logic                  sel_req_s;
  logic [RGB_W-1:0]      sel_rgb_s;

  assign lives_valid_s = (lives <= LIVES_W'(NUM_HEARTS));

`ifdef HEART_BLINK_EN
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BLINK = 1'b1;
  localparam int CNT_W  = $clog2(BLINK_FRAMES + 1);
  localparam int HALF_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  logic [0:0]         state_r, state_nx_s;
  logic [LIVES_W-1:0] lives_prev_r;
  logic [LIVES_W-1:0] blink_lo_r, blink_lo_nx_s;
  logic [LIVES_W-1:0] blink_hi_r, blink_hi_nx_s;
  logic [CNT_W-1:0]   frame_cnt_r, frame_cnt_nx_s;
  logic [HALF_W-1:0]  half_cnt_r, half_cnt_nx_s;
  logic               phase_on_r, phase_on_nx_s;

  // Blink FSM next-state: invalid lives > loss > lives increase > frame tick
  always_comb begin
    state_nx_s     = state_r;
    blink_lo_nx_s  = blink_lo_r;
    blink_hi_nx_s  = blink_hi_r;
    frame_cnt_nx_s = frame_cnt_r;
    half_cnt_nx_s  = half_cnt_r;
    phase_on_nx_s  = phase_on_r;
    if (!lives_valid_s) begin
      state_nx_s = ST_IDLE;
    end else if (lives < lives_prev_r) begin
      state_nx_s     = ST_BLINK;
      blink_lo_nx_s  = lives;
      blink_hi_nx_s  = (state_r == ST_BLINK) ? blink_hi_r : (lives_prev_r - LIVES_W'(1));
      frame_cnt_nx_s = {CNT_W{1'b0}};
      half_cnt_nx_s  = {HALF_W{1'b0}};
      phase_on_nx_s  = 1'b1;
    end else if (state_r == ST_BLINK) begin
      if (lives > lives_prev_r) begin
        state_nx_s = ST_IDLE;
      end else if (start_of_frame) begin
        frame_cnt_nx_s = frame_cnt_r + CNT_W'(1);
        if (half_cnt_r == HALF_W'(BLINK_HALF - 1)) begin
          half_cnt_nx_s = {HALF_W{1'b0}};
          phase_on_nx_s = ~phase_on_r;
        end else begin
          half_cnt_nx_s = half_cnt_r + HALF_W'(1);
        end
        if (frame_cnt_nx_s == CNT_W'(BLINK_FRAMES)) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_BLINK;
        end
      end else begin
        state_nx_s = ST_BLINK;
      end
    end else begin
      state_nx_s = ST_IDLE;
    end
  end

  // FSM, blink range, counters and previous-lives registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      lives_prev_r <= {LIVES_W{1'b0}};
      blink_lo_r   <= {LIVES_W{1'b0}};
      blink_hi_r   <= {LIVES_W{1'b0}};
      frame_cnt_r  <= {CNT_W{1'b0}};
      half_cnt_r   <= {HALF_W{1'b0}};
      phase_on_r   <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      blink_lo_r  <= blink_lo_nx_s;
      blink_hi_r  <= blink_hi_nx_s;
      frame_cnt_r <= frame_cnt_nx_s;
      half_cnt_r  <= half_cnt_nx_s;
      phase_on_r  <= phase_on_nx_s;
      if (lives_valid_s) begin
        lives_prev_r <= lives;
      end else begin
        lives_prev_r <= lives_prev_r;
      end
    end
  end

  // Visibility uses next-state values so a loss or abort shows with the same latency as lives
  always_comb begin
    visible_s  = {NUM_HEARTS{1'b0}};
    blink_nx_s = (state_nx_s == ST_BLINK);
    for (int i = 0; i < NUM_HEARTS; i++) begin
      visible_s[i] = (LIVES_W'(i) < lives) ||
                     (blink_nx_s && phase_on_nx_s &&
                      (LIVES_W'(i) >= blink_lo_nx_s) && (LIVES_W'(i) <= blink_hi_nx_s));
    end
  end
`else
  logic unused_start_of_frame_s;
  assign unused_start_of_frame_s = start_of_frame;

  // Steady hearts only: lost hearts vanish immediately
  always_comb begin
    visible_s  = {NUM_HEARTS{1'b0}};
    blink_nx_s = 1'b0;
    for (int i = 0; i < NUM_HEARTS; i++) begin
      visible_s[i] = (LIVES_W'(i) < lives);
    end
  end
`endif

  // Priority select: scan downwards so the lowest requesting visible heart wins
  always_comb begin
    sel_req_s = 1'b0;
    sel_rgb_s = {RGB_W{1'b0}};
    for (int i = NUM_HEARTS - 1; i >= 0; i--) begin
      if (lives_valid_s && visible_s[i] && heart_drawing_requests[i]) begin
        sel_req_s = 1'b1;
        sel_rgb_s = heart_rgb[i*RGB_W +: RGB_W];
      end else begin
        sel_req_s = sel_req_s;
        sel_rgb_s = sel_rgb_s;
      end
    end
  end

  // Registered pixel and status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      drawing_request <= 1'b0;
      rgb             <= {RGB_W{1'b0}};
      blinking        <= 1'b0;
    end else begin
      drawing_request <= sel_req_s;
      rgb             <= sel_rgb_s;
      blinking        <= blink_nx_s;
    end
  end

endmodule

// File: tb/tb_heart_bank_selector.sv
// Self-checking bench for heart_bank_selector against a frame-counting reference model.
module tb_heart_bank_selector;
  localparam int NH = 3;
  localparam int LW = 3;
  localparam int RW = 8;
  localparam int BF = 32;
  localparam int BH = 4;
`ifdef HEART_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          sof;
  logic [LW-1:0] lives;
  logic [NH-1:0] req;
  logic [NH*RW-1:0] hrgb;
  logic          dr;
  logic [RW-1:0] rgb;
  logic          blinking;

  int checks = 0;
  int failures = 0;

  // reference model state and expectations
  int m_prev, m_lo, m_hi, m_frames;
  bit m_blink;
  bit e_dr, e_blink;
  logic [RW-1:0] e_rgb;

  heart_bank_selector #(.NUM_HEARTS(NH), .LIVES_W(LW), .RGB_W(RW),
                        .BLINK_FRAMES(BF), .BLINK_HALF(BH)) dut (
    .clk(clk), .rst(rst), .start_of_frame(sof), .lives(lives),
    .heart_drawing_requests(req), .heart_rgb(hrgb),
    .drawing_request(dr), .rgb(rgb), .blinking(blinking));

  always #5 clk = ~clk;

  // advance the model with the current inputs, then clock the DUT
  task automatic tick();
    int lv;
    bit valid, on;
    lv = int'(lives);
    if (rst) begin
      m_prev = 0; m_blink = 1'b0; m_frames = 0;
      e_dr = 1'b0; e_rgb = 8'h00; e_blink = 1'b0;
    end else begin
      valid = (lv <= NH);
      if (BLINK_EN) begin
        if (!valid) m_blink = 1'b0;
        else if (lv < m_prev) begin
          if (!m_blink) m_hi = m_prev - 1;
          m_blink = 1'b1; m_lo = lv; m_frames = 0;
        end else if (m_blink && lv > m_prev) m_blink = 1'b0;
        else if (m_blink && sof) begin
          m_frames++;
          if (m_frames >= BF) m_blink = 1'b0;
        end
      end
      if (valid) m_prev = lv;
      on = ((m_frames / BH) % 2) == 0;
      e_dr = 1'b0; e_rgb = 8'h00;
      if (valid)
        for (int i = NH - 1; i >= 0; i--)
          if (req[i] && (i < lv || (m_blink && on && i >= m_lo && i <= m_hi))) begin
            e_dr = 1'b1; e_rgb = hrgb[i*RW +: RW];
          end
      e_blink = m_blink;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sof = 1'b1; lives = 3'd3; req = 3'b111; hrgb = 24'hA1B2C3;
    tick(); tick();
    checks++; if (dr !== 1'b0) begin failures++; $display("FAIL reset_dr got=%b exp=0", dr); end
    checks++; if (rgb !== 8'h00) begin failures++; $display("FAIL reset_rgb got=%h exp=00", rgb); end
    checks++; if (blinking !== 1'b0) begin failures++; $display("FAIL reset_blink got=%b exp=0", blinking); end
    rst = 1'b0; sof = 1'b0;
  endtask

  task automatic test_basic();
    lives = 3'd3; req = 3'b010; hrgb = {8'h55, 8'hE0, 8'h11};
    tick();
    checks++; if (dr !== 1'b1) begin failures++; $display("FAIL basic_dr got=%b exp=1", dr); end
    checks++; if (rgb !== 8'hE0) begin failures++; $display("FAIL basic_rgb got=%h exp=e0", rgb); end
    checks++; if (blinking !== 1'b0) begin failures++; $display("FAIL basic_blink got=%b exp=0", blinking); end
  endtask

  task automatic test_invalid();
    lives = 3'd4; req = 3'b111;
    tick();
    checks++; if (dr !== 1'b0) begin failures++; $display("FAIL invalid_dr got=%b exp=0", dr); end
    checks++; if (rgb !== 8'h00) begin failures++; $display("FAIL invalid_rgb got=%h exp=00", rgb); end
    checks++; if (blinking !== 1'b0) begin failures++; $display("FAIL invalid_blink got=%b exp=0", blinking); end
    lives = 3'd3;
    tick();
    checks++; if (blinking !== 1'b0) begin failures++; $display("FAIL invalid_prev_hold blink got=%b exp=0", blinking); end
    checks++; if (rgb !== hrgb[7:0]) begin failures++; $display("FAIL invalid_recover rgb got=%h exp=%h", rgb, hrgb[7:0]); end
  endtask

  task automatic test_priority();
    lives = 3'd3; req = 3'b011; hrgb = {8'h7C, 8'hFF, 8'h03};
    tick();
    checks++; if (rgb !== 8'h03) begin failures++; $display("FAIL priority_rgb got=%h exp=03", rgb); end
    checks++; if (dr !== 1'b1) begin failures++; $display("FAIL priority_dr got=%b exp=1", dr); end
  endtask

  // run frames of a few cycles each, comparing against the model every cycle
  task automatic run_frames(input int nframes, input string tag);
    for (int f = 0; f < nframes; f++) begin
      for (int c = 0; c < 3; c++) begin
        sof = (c == 0);
        tick();
        checks++;
        if (dr !== e_dr || rgb !== e_rgb || blinking !== e_blink) begin
          failures++;
          $display("FAIL %s frame=%0d got dr=%b rgb=%h blink=%b exp dr=%b rgb=%h blink=%b",
                   tag, f, dr, rgb, blinking, e_dr, e_rgb, e_blink);
        end
      end
    end
    sof = 1'b0;
  endtask

  task automatic test_loss_blink();
    lives = 3'd3; req = 3'b100; hrgb = {8'h1C, 8'h22, 8'h33};
    tick();
    lives = 3'd2;
    run_frames(36, "loss_blink");
    checks++; if (blinking !== 1'b0) begin failures++; $display("FAIL blink_end got=%b exp=0", blinking); end
    checks++; if (dr !== 1'b0) begin failures++; $display("FAIL blink_end_dr got=%b exp=0", dr); end
  endtask

  task automatic test_nested_loss();
    lives = 3'd3; req = 3'b110; hrgb = {8'h1C, 8'h90, 8'h33};
    tick();
    lives = 3'd2;
    run_frames(10, "nested_a");
    lives = 3'd1;
    run_frames(20, "nested_b");
    lives = 3'd3; req = 3'b111;
    run_frames(2, "nested_abort");
    checks++; if (blinking !== 1'b0) begin failures++; $display("FAIL abort_blink got=%b exp=0", blinking); end
    checks++; if (rgb !== 8'h33) begin failures++; $display("FAIL abort_rgb got=%h exp=33", rgb); end
    lives = 3'd2;
    run_frames(40, "nested_c");
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      sof = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 24) == 0) lives = LW'($urandom_range(0, 4));
      else if ($urandom_range(0, 99) == 0) lives = LW'($urandom_range(0, 7));
      req = NH'($urandom);
      hrgb = (NH*RW)'($urandom);
      tick();
      checks++;
      if (dr !== e_dr || rgb !== e_rgb || blinking !== e_blink) begin
        failures++;
        $display("FAIL random n=%0d got dr=%b rgb=%h blink=%b exp dr=%b rgb=%h blink=%b",
                 n, dr, rgb, blinking, e_dr, e_rgb, e_blink);
      end
    end
    rst = 1'b0; sof = 1'b0;
  endtask

  initial begin
    m_prev = 0; m_lo = 0; m_hi = 0; m_frames = 0; m_blink = 1'b0;
    test_reset();
    test_basic();
    test_invalid();
    test_priority();
    test_loss_blink();
    test_nested_loss();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
